// File: rtl/redmule_z_writeback_buffer.sv
// Double-banked column-to-row transpose buffer between the RedMulE array and the Z writeback port.
// Latency: first row is offered the cycle after the column that completes a tile is accepted.
// Backpressure: fill stalls while both banks hold tiles; a row stays stable until wb_ready_i.

package redmule_z_wb_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    localparam int unsigned ARRAY_WIDTH = 12;

    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP32:          return 32;
            FP64:          return 64;
            FP16, FP16ALT: return 16;
            FP8:           return 8;
            default:       return 16;
        endcase
    endfunction

endpackage

module redmule_z_writeback_buffer
    import redmule_z_wb_pkg::*;
#(
    parameter  int unsigned DW       = 288,
    parameter  fp_format_e  FpFormat = FP16,
    parameter  int unsigned Width    = ARRAY_WIDTH,
    localparam int unsigned BITW     = fp_width(FpFormat),
    localparam int unsigned W        = Width,
    localparam int unsigned L        = DW / BITW,
    localparam int unsigned CW       = $clog2(L) + 1,
    localparam int unsigned RW       = $clog2(W) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              cfg_setup_i,
    input  logic [CW-1:0]     cols_i,
    input  logic [RW-1:0]     rows_i,
    input  logic              fill_valid_i,
    output logic              fill_ready_o,
    input  logic [W*BITW-1:0] z_i,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [DW-1:0]     wb_data_o,
    output logic [DW/8-1:0]   wb_strb_o,
    output logic              full_o,
    output logic              empty_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e                  state_q;
    logic [1:0]              bank_valid_q;
    logic [1:0]              bank_valid_d;
    logic                    wb_q;
    logic                    rb_q;
    logic [CW-1:0]           col_q;
    logic [RW-1:0]           row_q;
    logic [CW-1:0]           cfg_cols_q;
    logic [RW-1:0]           cfg_rows_q;

    logic [L-1:0][BITW-1:0]  mem_q [2][W];
    logic [L-1:0][BITW-1:0]  rd_row;
    logic [31:0]             strb_bytes;

    logic                    fill_fire;
    logic                    fill_done;
    logic                    drain_fire;
    logic                    drain_done;

    assign fill_ready_o = ~bank_valid_q[wb_q];
    assign fill_fire    = fill_valid_i & fill_ready_o;
    assign fill_done    = fill_fire & (col_q == cfg_cols_q - CW'(1));
    assign drain_fire   = (state_q == DRAIN) & wb_ready_i;
    assign drain_done   = drain_fire & (row_q == cfg_rows_q - RW'(1));

    // Fill and drain always target different banks, so both updates can land together.
    always_comb begin
        bank_valid_d = bank_valid_q;
        if (drain_done) begin
            bank_valid_d[rb_q] = 1'b0;
        end
        if (fill_done) begin
            bank_valid_d[wb_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            bank_valid_q <= 2'b00;
            wb_q         <= 1'b0;
            col_q        <= '0;
            cfg_cols_q   <= CW'(L);
            cfg_rows_q   <= RW'(W);
        end else begin
            bank_valid_q <= bank_valid_d;
            if (cfg_setup_i) begin
                cfg_cols_q <= cols_i;
                cfg_rows_q <= rows_i;
            end
            if (fill_done) begin
                col_q <= '0;
                wb_q  <= ~wb_q;
            end else if (fill_fire) begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= IDLE;
            rb_q    <= 1'b0;
            row_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bank_valid_d[rb_q]) begin
                        state_q <= DRAIN;
                        row_q   <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        rb_q    <= ~rb_q;
                        row_q   <= '0;
                        state_q <= bank_valid_d[~rb_q] ? DRAIN : IDLE;
                    end else if (drain_fire) begin
                        row_q <= row_q + RW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage is not reset: bank_valid alone decides whether its contents are meaningful.
    always_ff @(posedge clk_i) begin
        if (fill_fire) begin
            for (int unsigned r = 0; r < W; r++) begin
                for (int unsigned c = 0; c < L; c++) begin
                    if (col_q == CW'(c)) begin
                        mem_q[wb_q][r][c] <= z_i[r*BITW +: BITW];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_row = '0;
        for (int unsigned r = 0; r < W; r++) begin
            if (row_q == RW'(r)) begin
                rd_row = mem_q[rb_q][r];
            end
        end
    end

    assign strb_bytes = (32'(cfg_cols_q) * BITW) / 8;

    always_comb begin
        wb_data_o = '0;
        wb_strb_o = '0;
        if (state_q == DRAIN) begin
            for (int unsigned c = 0; c < L; c++) begin
                if (CW'(c) < cfg_cols_q) begin
                    wb_data_o[c*BITW +: BITW] = rd_row[c];
                end
            end
            for (int unsigned b = 0; b < DW/8; b++) begin
                if (b < strb_bytes) begin
                    wb_strb_o[b] = 1'b1;
                end
            end
        end
    end

    assign wb_valid_o = (state_q == DRAIN);
    assign full_o     = &bank_valid_q;
    assign empty_o    = ~|bank_valid_q && (col_q == '0);

endmodule

// File: tb/tb_redmule_z_writeback_buffer.sv
// Randomized bench for redmule_z_writeback_buffer against a tile-queue reference model.

module tb_redmule_z_writeback_buffer;

    localparam int W    = 12;
    localparam int DW   = 288;
    localparam int BITW = 16;
    localparam int L    = DW / BITW;
    localparam int CW   = $clog2(L) + 1;
    localparam int RW   = $clog2(W) + 1;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              clear_i;
    logic              cfg_setup_i;
    logic [CW-1:0]     cols_i;
    logic [RW-1:0]     rows_i;
    logic              fill_valid_i;
    logic              fill_ready_o;
    logic [W*BITW-1:0] z_i;
    logic              wb_valid_o;
    logic              wb_ready_i;
    logic [DW-1:0]     wb_data_o;
    logic [DW/8-1:0]   wb_strb_o;
    logic              full_o;
    logic              empty_o;

    redmule_z_writeback_buffer #(
        .DW       (DW),
        .FpFormat (redmule_z_wb_pkg::FP16),
        .Width    (W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .cfg_setup_i  (cfg_setup_i),
        .cols_i       (cols_i),
        .rows_i       (rows_i),
        .fill_valid_i (fill_valid_i),
        .fill_ready_o (fill_ready_o),
        .z_i          (z_i),
        .wb_valid_o   (wb_valid_o),
        .wb_ready_i   (wb_ready_i),
        .wb_data_o    (wb_data_o),
        .wb_strb_o    (wb_strb_o),
        .full_o       (full_o),
        .empty_o      (empty_o)
    );

    always #5 clk = ~clk;

    // Reference model: expected output rows in emission order, rows left per held tile.
    logic [DW-1:0]   rowq[$];
    int              tile_rows[$];
    logic [BITW-1:0] part [W][L];
    int              m_cols = L;
    int              m_rows = W;
    int              fcol   = 0;
    int              cols_accepted = 0;
    int              total  = 0;
    int              bad    = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW/8-1:0] strb_of(input int cols);
        logic [63:0] m;
        m = (64'd1 << (cols * BITW / 8)) - 64'd1;
        return m[DW/8-1:0];
    endfunction

    task automatic check_outputs();
        logic exp_valid;
        exp_valid = (tile_rows.size() > 0);
        chk("wb_valid",   {287'd0, wb_valid_o},   {287'd0, exp_valid});
        chk("fill_ready", {287'd0, fill_ready_o}, {287'd0, tile_rows.size() < 2});
        chk("full",       {287'd0, full_o},       {287'd0, tile_rows.size() == 2});
        chk("empty",      {287'd0, empty_o},      {287'd0, tile_rows.size() == 0 && fcol == 0});
        chk("wb_data",    wb_data_o, exp_valid ? rowq[0] : '0);
        chk("wb_strb",    {252'd0, wb_strb_o}, exp_valid ? {252'd0, strb_of(m_cols)} : '0);
    endtask

    task automatic model_edge();
        logic          acc;
        logic          hs;
        logic [DW-1:0] word;
        if (rst_i || clear_i) begin
            rowq.delete();
            tile_rows.delete();
            fcol   = 0;
            m_cols = L;
            m_rows = W;
            return;
        end
        acc = fill_valid_i && (tile_rows.size() < 2);
        hs  = wb_ready_i && (tile_rows.size() > 0);
        if (hs) begin
            void'(rowq.pop_front());
            tile_rows[0] = tile_rows[0] - 1;
            if (tile_rows[0] == 0) void'(tile_rows.pop_front());
        end
        if (acc) begin
            cols_accepted++;
            for (int r = 0; r < W; r++) part[r][fcol] = z_i[r*BITW +: BITW];
            fcol++;
            if (fcol == m_cols) begin
                for (int r = 0; r < m_rows; r++) begin
                    word = '0;
                    for (int c = 0; c < m_cols; c++) word[c*BITW +: BITW] = part[r][c];
                    rowq.push_back(word);
                end
                tile_rows.push_back(m_rows);
                fcol = 0;
            end
        end
        if (cfg_setup_i) begin
            m_cols = int'(cols_i);
            m_rows = int'(rows_i);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_z();
        for (int r = 0; r < W; r++) z_i[r*BITW +: BITW] = 16'($urandom);
    endtask

    task automatic setup(input int c, input int r);
        fill_valid_i = 1'b0;
        cfg_setup_i  = 1'b1;
        cols_i       = CW'(c);
        rows_i       = RW'(r);
        cyc();
        cfg_setup_i  = 1'b0;
    endtask

    task automatic drain_all();
        fill_valid_i = 1'b0;
        wb_ready_i   = 1'b1;
        for (int i = 0; i < 400 && tile_rows.size() > 0; i++) cyc();
    endtask

    task automatic finish_partial();
        wb_ready_i = 1'b1;
        for (int i = 0; i < 100 && fcol != 0; i++) begin
            fill_valid_i = 1'b1;
            rand_z();
            cyc();
        end
        fill_valid_i = 1'b0;
    endtask

    initial begin
        rst_i        = 1'b1;
        clear_i      = 1'b0;
        cfg_setup_i  = 1'b0;
        cols_i       = '0;
        rows_i       = '0;
        fill_valid_i = 1'b0;
        wb_ready_i   = 1'b0;
        z_i          = '0;
        cyc();
        cyc();
        rst_i = 1'b0;
        cyc();

        // Full tile: every element of column c carries the value c.
        setup(18, 12);
        wb_ready_i = 1'b1;
        for (int c = 0; c < 18; c++) begin
            fill_valid_i = 1'b1;
            for (int r = 0; r < W; r++) z_i[r*BITW +: BITW] = 16'(c);
            cyc();
        end
        fill_valid_i = 1'b0;
        chk("full_tile_latency", {287'd0, wb_valid_o}, {287'd0, 1'b1});
        drain_all();

        // Narrow tile: 5 columns, 7 rows.
        setup(5, 7);
        for (int c = 0; c < 5; c++) begin
            fill_valid_i = 1'b1;
            rand_z();
            cyc();
        end
        fill_valid_i = 1'b0;
        chk("narrow_latency", {287'd0, wb_valid_o}, {287'd0, 1'b1});
        chk("narrow_strb", {252'd0, wb_strb_o}, {252'd0, 36'h0_0000_03FF});
        drain_all();
        chk("narrow_idle", {287'd0, wb_valid_o}, {287'd0, 1'b0});

        // Three tiles against a stalled memory side.
        setup(4, 3);
        wb_ready_i    = 1'b0;
        cols_accepted = 0;
        for (int i = 0; i < 16; i++) begin
            fill_valid_i = 1'b1;
            rand_z();
            cyc();
        end
        chk("stall_full",  {287'd0, full_o},       {287'd0, 1'b1});
        chk("stall_ready", {287'd0, fill_ready_o}, {287'd0, 1'b0});
        wb_ready_i = 1'b1;
        for (int i = 0; i < 60 && cols_accepted < 12; i++) begin
            fill_valid_i = 1'b1;
            rand_z();
            cyc();
        end
        fill_valid_i = 1'b0;
        drain_all();

        // Last fill of the second bank coincides with the last drain of the first.
        setup(2, 3);
        wb_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fill_valid_i = 1'b1;
            rand_z();
            cyc();
        end
        fill_valid_i = 1'b0;
        wb_ready_i   = 1'b1;
        cyc();
        cyc();
        fill_valid_i = 1'b1;
        rand_z();
        cyc();
        fill_valid_i = 1'b0;
        chk("overlap_stays_drain", {287'd0, wb_valid_o}, {287'd0, 1'b1});
        drain_all();

        // Random fill/drain pressure over several shapes.
        for (int k = 0; k < 4; k++) begin
            setup($urandom_range(1, 18), $urandom_range(1, 12));
            for (int i = 0; i < 150; i++) begin
                fill_valid_i = 1'($urandom_range(0, 1));
                wb_ready_i   = 1'($urandom_range(0, 1));
                rand_z();
                cyc();
            end
            finish_partial();
            drain_all();
        end

        // Soft clear in the middle of a drain.
        setup(3, 6);
        wb_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            fill_valid_i = 1'b1;
            rand_z();
            cyc();
        end
        fill_valid_i = 1'b0;
        cyc();
        cyc();
        cyc();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        chk("clear_valid", {287'd0, wb_valid_o},   {287'd0, 1'b0});
        chk("clear_empty", {287'd0, empty_o},      {287'd0, 1'b1});
        chk("clear_ready", {287'd0, fill_ready_o}, {287'd0, 1'b1});
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
